// File: rtl/decode_nlane.sv
// Kyber ByteDecode_d stream unpacker with optional Decompress_d.
// Unpacks IW-bit byte words into NLANE 12-bit coefficients per beat.
module decode_nlane #(
    parameter int IW    = 64,
    parameter int NLANE = 4,
    parameter int NPOLY = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [3:0]           i_l,
    input  logic                 i_decomp,
    input  logic [2:0]           i_npoly,
    input  logic [IW-1:0]        i_ibytes,
    input  logic                 i_ibytes_valid,
    output logic                 o_ibytes_ready,
    output logic [16*NLANE-1:0]  o_coeffs,
    output logic                 o_coeffs_valid,
    input  logic                 i_coeffs_ready,
    output logic [1:0]           o_poly_idx,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int BUFW = IW + 12 * NLANE;
    localparam int FW   = $clog2(BUFW + 1);
    localparam int WCW  = 16;
    localparam int CQ   = 3329;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state;
    state_t state_n;

    logic [BUFW-1:0]      bbuf;
    logic [BUFW-1:0]      buf_n;
    logic [BUFW-1:0]      sh_buf;
    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_n;
    logic [FW-1:0]        sh_fill;
    logic [FW-1:0]        bpb;
    logic [3:0]           d_q;
    logic                 dec_q;
    logic [2:0]           np_q;
    logic [WCW-1:0]       wrem;
    logic [WCW-1:0]       wjob;
    logic [7:0]           coef_cnt;
    logic [1:0]           ld_poly;
    logic                 out_last;
    logic                 legal;
    logic                 in_fire;
    logic                 out_fire;
    logic                 ext;
    logic                 last_beat;
    logic [11:0]          mask;
    logic [16*NLANE-1:0]  lanes;

    // Reduce (d=12), decompress, or pass a raw d-bit field.
    function automatic logic [11:0] conv(
        input logic [11:0] x,
        input logic [3:0]  d,
        input logic        dec
    );
        logic [23:0] p;
        p = 24'(CQ) * {12'd0, x} + (24'd1 << (d - 4'd1));
        if (d == 4'd12)
            return (x >= 12'(CQ)) ? x - 12'(CQ) : x;
        else if (dec)
            return 12'(p >> d);
        else
            return x;
    endfunction

    assign legal = (i_l != 4'd0) && (i_l <= 4'd12) &&
                   (i_npoly != 3'd0) &&
                   (32'(i_npoly) <= 32'(NPOLY));

    assign wjob = WCW'(i_npoly) *
                  ((WCW'(i_l) << 8) / WCW'(IW));

    assign bpb = FW'(NLANE) * FW'(d_q);

    assign o_ibytes_ready = (state == S_RUN) &&
                            ((32'(fill) + 32'(IW)) <= 32'(BUFW)) &&
                            (wrem != '0);

    assign in_fire  = o_ibytes_ready && i_ibytes_valid;
    assign out_fire = o_coeffs_valid && i_coeffs_ready;

    assign ext = (state != S_IDLE) && (fill >= bpb) &&
                 (!o_coeffs_valid || i_coeffs_ready);

    assign last_beat = (ld_poly == 2'(np_q - 3'd1)) &&
                       (coef_cnt == 8'(256 - NLANE));

    assign mask = (12'd1 << d_q) - 12'd1;

    // Slice NLANE d-bit fields from the buffer bottom and convert them.
    always_comb begin
        lanes = '0;
        for (int n = 0; n < NLANE; n++) begin
            lanes[16*n +: 16] = {4'd0, conv(
                12'(bbuf >> (n * int'(d_q))) & mask,
                d_q, dec_q)};
        end
    end

    // Next buffer: drop extracted bits, append accepted word at fill.
    always_comb begin
        sh_buf  = ext ? (bbuf >> bpb) : bbuf;
        sh_fill = ext ? (fill - bpb) : fill;
        buf_n   = sh_buf;
        fill_n  = sh_fill;
        if (in_fire) begin
            buf_n  = sh_buf |
                     ({{(BUFW-IW){1'b0}}, i_ibytes} << sh_fill);
            fill_n = sh_fill + FW'(IW);
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next-state and done pulse.
    always_comb begin
        state_n = state;
        o_done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_start && legal)
                    state_n = S_RUN;
            end
            S_RUN: begin
                if (in_fire && (wrem == WCW'(1)))
                    state_n = S_FLUSH;
            end
            S_FLUSH: begin
                if (out_fire && out_last) begin
                    o_done  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Job config, bit buffer, output register and beat counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bbuf           <= '0;
            fill           <= '0;
            d_q            <= '0;
            dec_q          <= 1'b0;
            np_q           <= '0;
            wrem           <= '0;
            coef_cnt       <= '0;
            ld_poly        <= '0;
            out_last       <= 1'b0;
            o_coeffs       <= '0;
            o_coeffs_valid <= 1'b0;
            o_poly_idx     <= '0;
            o_err          <= 1'b0;
        end else begin
            o_err <= 1'b0;
            bbuf  <= buf_n;
            fill  <= fill_n;
            if ((state == S_IDLE) && i_start) begin
                if (legal) begin
                    d_q        <= i_l;
                    dec_q      <= i_decomp;
                    np_q       <= i_npoly;
                    wrem       <= wjob;
                    coef_cnt   <= '0;
                    ld_poly    <= '0;
                    o_poly_idx <= '0;
                end else begin
                    o_err <= 1'b1;
                end
            end
            if (in_fire)
                wrem <= wrem - WCW'(1);
            if (ext) begin
                o_coeffs       <= lanes;
                o_coeffs_valid <= 1'b1;
                o_poly_idx     <= ld_poly;
                out_last       <= last_beat;
                coef_cnt       <= coef_cnt + 8'(NLANE);
                if (coef_cnt == 8'(256 - NLANE))
                    ld_poly <= ld_poly + 2'd1;
            end else if (out_fire) begin
                o_coeffs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_nlane.sv
// Scoreboard bench for decode_nlane.
// Directed byte patterns plus a bit-level golden model.
module tb_decode_nlane;

    localparam int IW    = 64;
    localparam int NLANE = 4;
    localparam int NPOLY = 4;
    localparam int BPP   = 256 / NLANE;

    logic                clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_start = 1'b0;
    logic [3:0]          i_l = '0;
    logic                i_decomp = 1'b0;
    logic [2:0]          i_npoly = '0;
    logic [IW-1:0]       i_ibytes = '0;
    logic                i_ibytes_valid = 1'b0;
    logic                o_ibytes_ready;
    logic [16*NLANE-1:0] o_coeffs;
    logic                o_coeffs_valid;
    logic                i_coeffs_ready = 1'b1;
    logic [1:0]          o_poly_idx;
    logic                o_done;
    logic                o_err;

    always #5 clk = ~clk;

    decode_nlane #(.IW(IW), .NLANE(NLANE), .NPOLY(NPOLY)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_l            (i_l),
        .i_decomp       (i_decomp),
        .i_npoly        (i_npoly),
        .i_ibytes       (i_ibytes),
        .i_ibytes_valid (i_ibytes_valid),
        .o_ibytes_ready (o_ibytes_ready),
        .o_coeffs       (o_coeffs),
        .o_coeffs_valid (o_coeffs_valid),
        .i_coeffs_ready (i_coeffs_ready),
        .o_poly_idx     (o_poly_idx),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    logic [16*NLANE-1:0] exp_q[$];
    logic [1:0]          exp_pq[$];
    int                  errors = 0;
    int                  checks = 0;
    int                  done_cnt = 0;
    int                  beats = 0;
    bit                  mon_en = 1'b0;
    bit                  rnd_rdy = 1'b0;
    bit                  rnd_vld = 1'b0;
    bit                  was_stall = 1'b0;
    logic [16*NLANE-1:0] held = '0;
    logic [7:0]          bq[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [63:0] beat4(input int a, input int b,
                                          input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Monitor: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        if (mon_en) begin
            if (was_stall) begin
                chk("stall_valid", 64'(o_coeffs_valid), 64'd1);
                chk("stall_data", o_coeffs, held);
            end
            was_stall = o_coeffs_valid && !i_coeffs_ready;
            held = o_coeffs;
            if (o_coeffs_valid && i_coeffs_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %0h expected none",
                             o_coeffs);
                end else begin
                    chk("beat", o_coeffs, exp_q.pop_front());
                    chk("poly_idx", 64'(o_poly_idx), 64'(exp_pq.pop_front()));
                end
            end
            if (o_done) begin
                done_cnt++;
                chk("done_last", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    // Downstream ready, optionally throttled.
    initial forever begin
        @(posedge clk);
        #1;
        i_coeffs_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_const(input logic [63:0] v, input int np);
        for (int p = 0; p < np; p++)
            for (int b = 0; b < BPP; b++) begin
                exp_q.push_back(v);
                exp_pq.push_back(2'(p));
            end
    endtask

    task automatic push_model(input int d, input bit dec, input int np);
        for (int p = 0; p < np; p++)
            for (int b = 0; b < BPP; b++) begin
                logic [63:0] bt;
                bt = '0;
                for (int n = 0; n < NLANE; n++) begin
                    int pos;
                    int x;
                    int y;
                    logic [7:0] by;
                    pos = p * 256 * d + (b * NLANE + n) * d;
                    x = 0;
                    for (int j = 0; j < d; j++) begin
                        by = bq[(pos + j) / 8];
                        if (by[(pos + j) % 8]) x = x + (1 << j);
                    end
                    if (d == 12) y = (x >= 3329) ? x - 3329 : x;
                    else if (dec) y = (3329 * x + (1 << (d - 1))) >> d;
                    else y = x;
                    bt[16*n +: 16] = 16'(y);
                end
                exp_q.push_back(bt);
                exp_pq.push_back(2'(p));
            end
    endtask

    task automatic fill_pat(input int n, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c,
                            input int period);
        bq.delete();
        for (int i = 0; i < n; i++) begin
            if (i % period == 0) bq.push_back(a);
            else if (i % period == 1) bq.push_back(b);
            else bq.push_back(c);
        end
    endtask

    task automatic fill_rand(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    endtask

    task automatic send_word(input logic [IW-1:0] w);
        int t;
        t = 0;
        i_ibytes = w;
        if (rnd_vld)
            while ($urandom_range(0, 2) == 0) begin
                i_ibytes_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        i_ibytes_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (o_ibytes_ready) break;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no ready expected ready");
                break;
            end
        end
        @(posedge clk);
        #1;
        i_ibytes_valid = 1'b0;
    endtask

    task automatic send_bytes(input int nwords);
        for (int w = 0; w < nwords; w++) begin
            logic [IW-1:0] wd;
            for (int k = 0; k < IW / 8; k++)
                wd[8*k +: 8] = bq[w * (IW / 8) + k];
            send_word(wd);
        end
    endtask

    task automatic start_job(input int d, input bit dec, input int np);
        @(posedge clk);
        #1;
        i_l = 4'(d);
        i_decomp = dec;
        i_npoly = 3'(np);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic run_job(input string name, input int d, input bit dec,
                           input int np);
        int d0;
        int b0;
        int t;
        d0 = done_cnt;
        b0 = beats;
        start_job(d, dec, np);
        send_bytes(np * 256 * d / IW);
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({name, "_done"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_beats"}, 64'(beats - b0), 64'(np * BPP));
        chk({name, "_qempty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_idle_rdy"}, 64'(o_ibytes_ready), 64'd0);
        exp_q.delete();
        exp_pq.delete();
    endtask

    task automatic illegal(input string name, input int l, input int np);
        @(posedge clk);
        #1;
        i_l = 4'(l);
        i_npoly = 3'(np);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        chk({name, "_err"}, 64'(o_err), 64'd1);
        chk({name, "_rdy"}, 64'(o_ibytes_ready), 64'd0);
        @(negedge clk);
        chk({name, "_err_clr"}, 64'(o_err), 64'd0);
        chk({name, "_rdy2"}, 64'(o_ibytes_ready), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(o_coeffs_valid), 64'd0);
        chk("rst_ready", 64'(o_ibytes_ready), 64'd0);
        chk("rst_coeffs", o_coeffs, 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_poly", 64'(o_poly_idx), 64'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        mon_en = 1'b1;

        fill_pat(32, 8'hFF, 8'hFF, 8'hFF, 3);
        push_const(beat4(1, 1, 1, 1), 1);
        run_job("d1_raw", 1, 1'b0, 1);

        push_const(beat4(1665, 1665, 1665, 1665), 1);
        run_job("d1_dec_ones", 1, 1'b1, 1);

        fill_pat(32, 8'h00, 8'h00, 8'h00, 3);
        push_const(beat4(0, 0, 0, 0), 1);
        run_job("d1_dec_zero", 1, 1'b1, 1);

        fill_pat(384, 8'hFF, 8'hFF, 8'hFF, 3);
        push_const(beat4(766, 766, 766, 766), 1);
        run_job("d12_ff", 12, 1'b1, 1);

        fill_pat(384, 8'h01, 8'h0D, 8'hFF, 3);
        push_const(beat4(0, 751, 0, 751), 1);
        run_job("d12_q", 12, 1'b0, 1);

        fill_pat(128, 8'hF0, 8'hF0, 8'hF0, 3);
        push_const(beat4(0, 3121, 0, 3121), 1);
        run_job("d4_dec", 4, 1'b1, 1);

        push_const(beat4(0, 15, 0, 15), 1);
        run_job("d4_raw", 4, 1'b0, 1);

        rnd_rdy = 1'b1;
        rnd_vld = 1'b1;
        fill_rand(3 * 320);
        push_model(10, 1'b0, 3);
        run_job("d10_np3", 10, 1'b0, 3);
        rnd_rdy = 1'b0;
        rnd_vld = 1'b0;

        illegal("ill_l0", 0, 1);
        illegal("ill_l13", 13, 1);
        illegal("ill_np0", 4, 0);

        mon_en = 1'b0;
        fill_rand(160);
        start_job(5, 1'b0, 1);
        send_bytes(3);
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(o_coeffs_valid), 64'd0);
        chk("midrst_ready", 64'(o_ibytes_ready), 64'd0);
        chk("midrst_poly", 64'(o_poly_idx), 64'd0);
        exp_q.delete();
        exp_pq.delete();
        was_stall = 1'b0;
        mon_en = 1'b1;

        rnd_rdy = 1'b1;
        fill_rand(2 * 160);
        push_model(5, 1'b1, 2);
        run_job("d5_fresh", 5, 1'b1, 2);
        rnd_rdy = 1'b0;

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
